fetch_unit: RTL

- Instruction-fetch front end that consumes the PC register output.
- Issues instruction-memory requests at pc_i with a req/gnt plus rvalid handshake.
- Drives pc_write_o back to the PC register so the PC advances only when a fetch is granted or a redirect occurs.
- Buffers returned instructions in a small queue feeding the IF/ID boundary, with stall and flush support.

---
 rtl/fetch_imem_if.sv | 11 +
 rtl/fetch_unit.sv | 118 +++++++++++
 2 files changed

// File: rtl/fetch_imem_if.sv
// Instruction-memory request/response bus: req/gnt address phase, rvalid data phase.
interface fetch_imem_if #(parameter int XLEN = 32);
   logic            req;
   logic [XLEN-1:0] addr;
   logic            gnt;
   logic            rvalid;
   logic [XLEN-1:0] rdata;

   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: one outstanding imem request, small in-order queue to ID.
// Optional request-stall counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [XLEN-1:0]   pc_i,
   output logic              pc_write_o,
   input  logic              flush_i,
   fetch_imem_if.master      imem,
   output logic              inst_valid_o,
   output logic [XLEN-1:0]   inst_o,
   output logic [XLEN-1:0]   inst_pc_o,
   input  logic              id_stall_i,
   output logic [31:0]       perf_stall_cnt_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pending_pc_q, pending_pc_d;
   logic [CW-1:0]   count_q;
   logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
   logic [XLEN-1:0] pc_mem_q  [DEPTH];
   logic [XLEN-1:0] ins_mem_q [DEPTH];
   logic            req_c, outstanding, space, push, pop;
   logic [XLEN-1:0] addr_c;

   // Space counts the response still owed by memory, so the queue never overflows.
   assign outstanding = (state_q == WAIT) || (state_q == DROP);
   assign space       = (count_q + CW'(outstanding)) < CW'(DEPTH);
   assign push        = (state_q == WAIT) & imem.rvalid & ~flush_i;
   assign pop         = inst_valid_o & ~id_stall_i;

   always_comb begin
      state_d      = state_q;
      pending_pc_d = pending_pc_q;
      req_c        = 1'b0;
      addr_c       = '0;
      case (state_q)
         IDLE: if (start_i && space && !flush_i) state_d = REQ;
         REQ: begin
            req_c  = ~flush_i;
            addr_c = pc_i;
            if (flush_i) state_d = IDLE;
            else if (imem.gnt) begin
               pending_pc_d = pc_i;
               state_d      = WAIT;
            end
         end
         WAIT: begin
            if (flush_i) state_d = imem.rvalid ? IDLE : DROP;
            else if (imem.rvalid)
               state_d = (start_i && ((count_q + CW'(1) - CW'(pop)) < CW'(DEPTH))) ? REQ : IDLE;
         end
         DROP: if (imem.rvalid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign imem.req   = req_c;
   assign imem.addr  = addr_c;
   assign pc_write_o = flush_i | (req_c & imem.gnt);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= IDLE;
         pending_pc_q <= '0;
      end else begin
         state_q      <= state_d;
         pending_pc_q <= pending_pc_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]  <= '0;
            ins_mem_q[i] <= '0;
         end
      end else if (flush_i) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         if (push) begin
            pc_mem_q[wr_ptr_q]  <= pending_pc_q;
            ins_mem_q[wr_ptr_q] <= imem.rdata;
            wr_ptr_q            <= wr_ptr_q + AW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   assign inst_valid_o = (count_q != '0);
   assign inst_o       = ins_mem_q[rd_ptr_q];
   assign inst_pc_o    = pc_mem_q[rd_ptr_q];

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_q;
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                    perf_q <= '0;
      else if (req_c && !imem.gnt)   perf_q <= perf_q + 32'd1;
   end
   assign perf_stall_cnt_o = perf_q;
`else
   assign perf_stall_cnt_o = '0;
`endif
endmodule
